// File: rtl/mips_cpu_ctrl_seq.sv
// mips_cpu_ctrl_seq: multicycle control sequencer for the MIPS datapath.
// Fetches an instruction word, decodes it into the team ALU op code and an
// execution class, then walks FETCH -> DECODE -> EXEC -> {MEM -> WB | WB | FETCH}.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN (undecoded instructions halt the
// sequencer instead of retiring as a NOP).
//
// Handshake: an access (FETCH or MEM) is requested for as long as the state is
// held; it completes on the first cycle mem_waitrequest is low, including the
// very first cycle of the state (zero-wait).
module mips_cpu_ctrl_seq #(
  parameter int MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_rdata,
  input  logic        mem_waitrequest,
  input  logic        alu_cond,
  output logic [5:0]  alu_op,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic        alu_src_imm,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iaddr_sel,
  output logic        reg_write,
  output logic        link,
  output logic        pc_write,
  output logic        branch_taken,
  output logic        hilo_write,
  output logic        active,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU     = 4'd0,  // R/I-type ALU op, writes back
    CL_LOAD    = 4'd1,
    CL_STORE   = 4'd2,
    CL_BR      = 4'd3,  // branch / jump, no writeback
    CL_BR_LINK = 4'd4,  // branch / jump that writes PC+8 to $31
    CL_BR_WB   = 4'd5,  // JALR: redirect plus writeback to rd
    CL_MD      = 4'd6,  // MULT/MULTU/DIV/DIVU
    CL_HILO    = 4'd7,  // MTHI/MTLO
    CL_ILL     = 4'd8
  } iclass_t;

  // Team ALU op codes
  localparam logic [5:0] OP_ADDIU = 6'd0,  OP_ADDU  = 6'd1,  OP_AND   = 6'd2,  OP_ANDI  = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4,  OP_BGEZ  = 6'd5,  OP_BGEZAL= 6'd6,  OP_BGTZ  = 6'd7;
  localparam logic [5:0] OP_BLEZ  = 6'd8,  OP_BLTZ  = 6'd9,  OP_BLTZAL= 6'd10, OP_BNE   = 6'd11;
  localparam logic [5:0] OP_DIV   = 6'd12, OP_DIVU  = 6'd13, OP_J     = 6'd14, OP_JAL   = 6'd15;
  localparam logic [5:0] OP_JALR  = 6'd16, OP_JR    = 6'd17, OP_LB    = 6'd18, OP_LBU   = 6'd19;
  localparam logic [5:0] OP_LH    = 6'd20, OP_LHU   = 6'd21, OP_LUI   = 6'd22, OP_LW    = 6'd23;
  localparam logic [5:0] OP_LWL   = 6'd24, OP_LWR   = 6'd25, OP_MFHI  = 6'd26, OP_MFLO  = 6'd27;
  localparam logic [5:0] OP_MULT  = 6'd28, OP_MULTU = 6'd29, OP_OR    = 6'd30, OP_ORI   = 6'd31;
  localparam logic [5:0] OP_SB    = 6'd32, OP_SH    = 6'd33, OP_SLL   = 6'd34, OP_SLLV  = 6'd35;
  localparam logic [5:0] OP_SLT   = 6'd36, OP_SLTI  = 6'd37, OP_SLTIU = 6'd38, OP_SLTU  = 6'd39;
  localparam logic [5:0] OP_SRA   = 6'd40, OP_SRAV  = 6'd41, OP_SRL   = 6'd42, OP_SRLV  = 6'd43;
  localparam logic [5:0] OP_SUBU  = 6'd44, OP_SW    = 6'd45, OP_XOR   = 6'd46, OP_XORI  = 6'd47;
  localparam logic [5:0] OP_MTHI  = 6'd48, OP_MTLO  = 6'd49;

  localparam int MDW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;

  state_t         state, state_nx;
  iclass_t        cls;
  logic [15:0]    ir_lo;
  logic [MDW-1:0] md_cnt;
  logic           md_last;
  logic           fetch_done;

  logic [5:0]     dec_op;
  iclass_t        dec_cls;
  logic           dec_imm;

  logic mem_read_c, mem_write_c, iaddr_sel_c, reg_write_c, link_c;
  logic pc_write_c, branch_taken_c, hilo_write_c;

  // rs is a datapath operand only; the sequencer never looks at it
  logic unused_rs;
  assign unused_rs = ^instr_rdata[25:21];

  assign fetch_done = (state == ST_FETCH) && !mem_waitrequest;
  assign md_last    = (md_cnt == MDW'(MD_LATENCY - 1));

  // Decode the incoming word so alu_op/class are already stable during DECODE
  always_comb begin
    dec_op  = OP_ADDIU;
    dec_cls = CL_ILL;
    dec_imm = 1'b0;
    case (instr_rdata[31:26])
      6'h00: begin
        case (instr_rdata[5:0])
          6'h00: begin dec_op = OP_SLL;   dec_cls = CL_ALU;  end
          6'h02: begin dec_op = OP_SRL;   dec_cls = CL_ALU;  end
          6'h03: begin dec_op = OP_SRA;   dec_cls = CL_ALU;  end
          6'h04: begin dec_op = OP_SLLV;  dec_cls = CL_ALU;  end
          6'h06: begin dec_op = OP_SRLV;  dec_cls = CL_ALU;  end
          6'h07: begin dec_op = OP_SRAV;  dec_cls = CL_ALU;  end
          6'h08: begin dec_op = OP_JR;    dec_cls = CL_BR;   end
          6'h09: begin dec_op = OP_JALR;  dec_cls = CL_BR_WB; end
          6'h10: begin dec_op = OP_MFHI;  dec_cls = CL_ALU;  end
          6'h11: begin dec_op = OP_MTHI;  dec_cls = CL_HILO; end
          6'h12: begin dec_op = OP_MFLO;  dec_cls = CL_ALU;  end
          6'h13: begin dec_op = OP_MTLO;  dec_cls = CL_HILO; end
          6'h18: begin dec_op = OP_MULT;  dec_cls = CL_MD;   end
          6'h19: begin dec_op = OP_MULTU; dec_cls = CL_MD;   end
          6'h1A: begin dec_op = OP_DIV;   dec_cls = CL_MD;   end
          6'h1B: begin dec_op = OP_DIVU;  dec_cls = CL_MD;   end
          6'h21: begin dec_op = OP_ADDU;  dec_cls = CL_ALU;  end
          6'h23: begin dec_op = OP_SUBU;  dec_cls = CL_ALU;  end
          6'h24: begin dec_op = OP_AND;   dec_cls = CL_ALU;  end
          6'h25: begin dec_op = OP_OR;    dec_cls = CL_ALU;  end
          6'h26: begin dec_op = OP_XOR;   dec_cls = CL_ALU;  end
          6'h2A: begin dec_op = OP_SLT;   dec_cls = CL_ALU;  end
          6'h2B: begin dec_op = OP_SLTU;  dec_cls = CL_ALU;  end
          default: ;
        endcase
      end
      6'h01: begin
        case (instr_rdata[20:16])
          5'h00: begin dec_op = OP_BLTZ;   dec_cls = CL_BR;      end
          5'h01: begin dec_op = OP_BGEZ;   dec_cls = CL_BR;      end
          5'h10: begin dec_op = OP_BLTZAL; dec_cls = CL_BR_LINK; end
          5'h11: begin dec_op = OP_BGEZAL; dec_cls = CL_BR_LINK; end
          default: ;
        endcase
      end
      6'h02: begin dec_op = OP_J;     dec_cls = CL_BR;      end
      6'h03: begin dec_op = OP_JAL;   dec_cls = CL_BR_LINK; end
      6'h04: begin dec_op = OP_BEQ;   dec_cls = CL_BR;      end
      6'h05: begin dec_op = OP_BNE;   dec_cls = CL_BR;      end
      6'h06: begin dec_op = OP_BLEZ;  dec_cls = CL_BR;      end
      6'h07: begin dec_op = OP_BGTZ;  dec_cls = CL_BR;      end
      6'h09: begin dec_op = OP_ADDIU; dec_cls = CL_ALU;   dec_imm = 1'b1; end
      6'h0A: begin dec_op = OP_SLTI;  dec_cls = CL_ALU;   dec_imm = 1'b1; end
      6'h0B: begin dec_op = OP_SLTIU; dec_cls = CL_ALU;   dec_imm = 1'b1; end
      6'h0C: begin dec_op = OP_ANDI;  dec_cls = CL_ALU;   dec_imm = 1'b1; end
      6'h0D: begin dec_op = OP_ORI;   dec_cls = CL_ALU;   dec_imm = 1'b1; end
      6'h0E: begin dec_op = OP_XORI;  dec_cls = CL_ALU;   dec_imm = 1'b1; end
      6'h0F: begin dec_op = OP_LUI;   dec_cls = CL_ALU;   dec_imm = 1'b1; end
      6'h20: begin dec_op = OP_LB;    dec_cls = CL_LOAD;  dec_imm = 1'b1; end
      6'h21: begin dec_op = OP_LH;    dec_cls = CL_LOAD;  dec_imm = 1'b1; end
      6'h22: begin dec_op = OP_LWL;   dec_cls = CL_LOAD;  dec_imm = 1'b1; end
      6'h23: begin dec_op = OP_LW;    dec_cls = CL_LOAD;  dec_imm = 1'b1; end
      6'h24: begin dec_op = OP_LBU;   dec_cls = CL_LOAD;  dec_imm = 1'b1; end
      6'h25: begin dec_op = OP_LHU;   dec_cls = CL_LOAD;  dec_imm = 1'b1; end
      6'h26: begin dec_op = OP_LWR;   dec_cls = CL_LOAD;  dec_imm = 1'b1; end
      6'h28: begin dec_op = OP_SB;    dec_cls = CL_STORE; dec_imm = 1'b1; end
      6'h29: begin dec_op = OP_SH;    dec_cls = CL_STORE; dec_imm = 1'b1; end
      6'h2B: begin dec_op = OP_SW;    dec_cls = CL_STORE; dec_imm = 1'b1; end
      default: ;
    endcase
  end

  // State register, instruction latch and MULT/DIV cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FETCH;
      ir_lo       <= 16'h0000;
      cls         <= CL_ALU;
      alu_op      <= 6'd0;
      alu_src_imm <= 1'b0;
      md_cnt      <= '0;
    end else begin
      state <= state_nx;
      if (fetch_done) begin
        ir_lo       <= instr_rdata[15:0];
        cls         <= dec_cls;
        alu_op      <= dec_op;
        alu_src_imm <= dec_imm;
      end
      if ((state == ST_EXEC) && (cls == CL_MD) && !md_last)
        md_cnt <= md_cnt + 1'b1;
      else
        md_cnt <= '0;
    end
  end

  // Next-state and per-state requests/strobes
  always_comb begin
    state_nx       = state;
    mem_read_c     = 1'b0;
    mem_write_c    = 1'b0;
    iaddr_sel_c    = 1'b0;
    reg_write_c    = 1'b0;
    link_c         = 1'b0;
    pc_write_c     = 1'b0;
    branch_taken_c = 1'b0;
    hilo_write_c   = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_read_c  = 1'b1;
        iaddr_sel_c = 1'b1;
        if (!mem_waitrequest) begin
          pc_write_c = 1'b1;
          state_nx   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls == CL_ILL) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_nx = ST_HALT;
`else
          state_nx = ST_FETCH;
`endif
        end else begin
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls)
          CL_MD: begin
            if (md_last) begin
              hilo_write_c = 1'b1;
              state_nx     = ST_FETCH;
            end
          end
          CL_HILO: begin
            hilo_write_c = 1'b1;
            state_nx     = ST_FETCH;
          end
          CL_BR: begin
            branch_taken_c = alu_cond;
            state_nx       = ST_FETCH;
          end
          CL_BR_LINK, CL_BR_WB: begin
            branch_taken_c = alu_cond;
            state_nx       = ST_WB;
          end
          CL_LOAD, CL_STORE: state_nx = ST_MEM;
          default:           state_nx = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (cls == CL_LOAD) mem_read_c  = 1'b1;
        else                mem_write_c = 1'b1;
        if (!mem_waitrequest)
          state_nx = (cls == CL_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        reg_write_c = 1'b1;
        link_c      = (cls == CL_BR_LINK);
        state_nx    = ST_FETCH;
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_FETCH;
    endcase
  end

  // Requests and strobes drop the moment reset asserts, even mid-access
  assign mem_read     = mem_read_c     & rst_n;
  assign mem_write    = mem_write_c    & rst_n;
  assign iaddr_sel    = iaddr_sel_c    & rst_n;
  assign reg_write    = reg_write_c    & rst_n;
  assign link         = link_c         & rst_n;
  assign pc_write     = pc_write_c     & rst_n;
  assign branch_taken = branch_taken_c & rst_n;
  assign hilo_write   = hilo_write_c   & rst_n;

  assign active    = (state != ST_HALT);
  assign shamt     = ir_lo[10:6];
  assign imm       = ir_lo;
  assign dbg_state = state;

endmodule

// File: tb/tb_mips_cpu_ctrl_seq.sv
// tb_mips_cpu_ctrl_seq: randomized bench for the control sequencer. A per-class
// timing model turns each instruction (plus its wait-state schedule) into the
// cycle-by-cycle list of expected strobes, queued in exp_q and compared live.
module tb_mips_cpu_ctrl_seq;

  localparam int MDL = 4;

  // expected-strobe vector bit positions
  localparam logic [8:0] E_A  = 9'h100;  // active
  localparam logic [8:0] E_MR = 9'h080;  // mem_read
  localparam logic [8:0] E_MW = 9'h040;  // mem_write
  localparam logic [8:0] E_IA = 9'h020;  // iaddr_sel
  localparam logic [8:0] E_PC = 9'h010;  // pc_write
  localparam logic [8:0] E_RW = 9'h008;  // reg_write
  localparam logic [8:0] E_LK = 9'h004;  // link
  localparam logic [8:0] E_BT = 9'h002;  // branch_taken
  localparam logic [8:0] E_HL = 9'h001;  // hilo_write

  localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_BR = 3, C_BRL = 4;
  localparam int C_BRW = 5, C_MD = 6, C_HL = 7, C_ILL = 8;

  logic        clk, rst_n;
  logic [31:0] instr_rdata;
  logic        mem_waitrequest, alu_cond;
  logic [5:0]  alu_op;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        alu_src_imm, mem_read, mem_write, iaddr_sel, reg_write, link;
  logic        pc_write, branch_taken, hilo_write, active;
  logic [2:0]  dbg_state;

  mips_cpu_ctrl_seq #(.MD_LATENCY(MDL)) dut (
    .clk(clk), .rst_n(rst_n), .instr_rdata(instr_rdata),
    .mem_waitrequest(mem_waitrequest), .alu_cond(alu_cond),
    .alu_op(alu_op), .shamt(shamt), .imm(imm), .alu_src_imm(alu_src_imm),
    .mem_read(mem_read), .mem_write(mem_write), .iaddr_sel(iaddr_sel),
    .reg_write(reg_write), .link(link), .pc_write(pc_write),
    .branch_taken(branch_taken), .hilo_write(hilo_write), .active(active),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [8:0]  exp_q[$];   // expected strobes per cycle
  logic [3:0]  ctl_q[$];   // {alu_cond, waitrequest, check decode fields, drive word}
  logic [31:0] cur_word;
  logic [31:0] cur_dec;

  typedef struct {
    logic [5:0] opc;
    logic [5:0] sub;   // funct for SPECIAL, rt for REGIMM
    logic [5:0] op;
    int         cls;
    bit         im;
  } ent_t;
  ent_t tab[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic [5:0] opc, input logic [5:0] sub, input logic [5:0] op,
                     input int cls, input bit im);
    ent_t e;
    e.opc = opc; e.sub = sub; e.op = op; e.cls = cls; e.im = im;
    tab.push_back(e);
  endtask

  // Instruction set and team op codes as a plain lookup table
  task automatic fill_table();
    add(6'h00, 6'h00, 6'd34, C_ALU, 0); add(6'h00, 6'h02, 6'd42, C_ALU, 0);
    add(6'h00, 6'h03, 6'd40, C_ALU, 0); add(6'h00, 6'h04, 6'd35, C_ALU, 0);
    add(6'h00, 6'h06, 6'd43, C_ALU, 0); add(6'h00, 6'h07, 6'd41, C_ALU, 0);
    add(6'h00, 6'h08, 6'd17, C_BR,  0); add(6'h00, 6'h09, 6'd16, C_BRW, 0);
    add(6'h00, 6'h10, 6'd26, C_ALU, 0); add(6'h00, 6'h11, 6'd48, C_HL,  0);
    add(6'h00, 6'h12, 6'd27, C_ALU, 0); add(6'h00, 6'h13, 6'd49, C_HL,  0);
    add(6'h00, 6'h18, 6'd28, C_MD,  0); add(6'h00, 6'h19, 6'd29, C_MD,  0);
    add(6'h00, 6'h1A, 6'd12, C_MD,  0); add(6'h00, 6'h1B, 6'd13, C_MD,  0);
    add(6'h00, 6'h21, 6'd1,  C_ALU, 0); add(6'h00, 6'h23, 6'd44, C_ALU, 0);
    add(6'h00, 6'h24, 6'd2,  C_ALU, 0); add(6'h00, 6'h25, 6'd30, C_ALU, 0);
    add(6'h00, 6'h26, 6'd46, C_ALU, 0); add(6'h00, 6'h2A, 6'd36, C_ALU, 0);
    add(6'h00, 6'h2B, 6'd39, C_ALU, 0);
    add(6'h01, 6'h00, 6'd9,  C_BR,  0); add(6'h01, 6'h01, 6'd5,  C_BR,  0);
    add(6'h01, 6'h10, 6'd10, C_BRL, 0); add(6'h01, 6'h11, 6'd6,  C_BRL, 0);
    add(6'h02, 6'h00, 6'd14, C_BR,  0); add(6'h03, 6'h00, 6'd15, C_BRL, 0);
    add(6'h04, 6'h00, 6'd4,  C_BR,  0); add(6'h05, 6'h00, 6'd11, C_BR,  0);
    add(6'h06, 6'h00, 6'd8,  C_BR,  0); add(6'h07, 6'h00, 6'd7,  C_BR,  0);
    add(6'h09, 6'h00, 6'd0,  C_ALU, 1); add(6'h0A, 6'h00, 6'd37, C_ALU, 1);
    add(6'h0B, 6'h00, 6'd38, C_ALU, 1); add(6'h0C, 6'h00, 6'd3,  C_ALU, 1);
    add(6'h0D, 6'h00, 6'd31, C_ALU, 1); add(6'h0E, 6'h00, 6'd47, C_ALU, 1);
    add(6'h0F, 6'h00, 6'd22, C_ALU, 1);
    add(6'h20, 6'h00, 6'd18, C_LD,  1); add(6'h21, 6'h00, 6'd20, C_LD,  1);
    add(6'h22, 6'h00, 6'd24, C_LD,  1); add(6'h23, 6'h00, 6'd23, C_LD,  1);
    add(6'h24, 6'h00, 6'd19, C_LD,  1); add(6'h25, 6'h00, 6'd21, C_LD,  1);
    add(6'h26, 6'h00, 6'd25, C_LD,  1);
    add(6'h28, 6'h00, 6'd32, C_ST,  1); add(6'h29, 6'h00, 6'd33, C_ST,  1);
    add(6'h2B, 6'h00, 6'd45, C_ST,  1);
  endtask

  task automatic lookup(input logic [31:0] w, output logic [5:0] op, output int cls, output bit im);
    op = 6'd0; cls = C_ILL; im = 1'b0;
    foreach (tab[i]) begin
      if (tab[i].opc == w[31:26] &&
          ((w[31:26] == 6'h00) ? (tab[i].sub == w[5:0]) :
           (w[31:26] == 6'h01) ? (tab[i].sub[4:0] == w[20:16]) : 1'b1)) begin
        op = tab[i].op; cls = tab[i].cls; im = tab[i].im;
      end
    end
  endtask

  task automatic push(input logic [8:0] e, input bit w, input bit c, input bit chk, input bit wd);
    exp_q.push_back(e);
    ctl_q.push_back({c, w, chk, wd});
  endtask

  // Timing model: fetch with fw wait states, one decode cycle, then per-class work
  task automatic build(input int cls, input int fw, input int mw, input bit cond);
    bit ok;
    ok = (cls != C_ILL);
    for (int i = 0; i < fw; i++) push(E_A | E_MR | E_IA, 1'b1, rb(), 1'b0, 1'b0);
    push(E_A | E_MR | E_IA | E_PC, 1'b0, rb(), 1'b0, 1'b1);
    push(E_A, rb(), rb(), ok, 1'b0);
    case (cls)
      C_ILL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) push(9'h000, rb(), rb(), 1'b0, 1'b0);
`endif
      end
      C_ALU: begin
        push(E_A, rb(), rb(), 1'b1, 1'b0);
        push(E_A | E_RW, rb(), rb(), 1'b1, 1'b0);
      end
      C_LD, C_ST: begin
        push(E_A, rb(), rb(), 1'b1, 1'b0);
        for (int i = 0; i < mw; i++) push(E_A | ((cls == C_LD) ? E_MR : E_MW), 1'b1, rb(), 1'b1, 1'b0);
        push(E_A | ((cls == C_LD) ? E_MR : E_MW), 1'b0, rb(), 1'b1, 1'b0);
        if (cls == C_LD) push(E_A | E_RW, rb(), rb(), 1'b1, 1'b0);
      end
      C_BR, C_BRL, C_BRW: begin
        push(E_A | (cond ? E_BT : 9'h000), rb(), cond, 1'b1, 1'b0);
        if (cls == C_BRL) push(E_A | E_RW | E_LK, rb(), rb(), 1'b1, 1'b0);
        if (cls == C_BRW) push(E_A | E_RW, rb(), rb(), 1'b1, 1'b0);
      end
      C_MD: begin
        for (int i = 0; i < MDL - 1; i++) push(E_A, rb(), rb(), 1'b1, 1'b0);
        push(E_A | E_HL, rb(), rb(), 1'b1, 1'b0);
      end
      default: push(E_A | E_HL, rb(), rb(), 1'b1, 1'b0);  // C_HL
    endcase
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drive, settle, compare, move to next falling edge
  task automatic play(input int n);
    logic [8:0] e;
    logic [3:0] c;
    for (int k = 0; k < n && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      c = ctl_q.pop_front();
      alu_cond        = c[3];
      mem_waitrequest = c[2];
      instr_rdata     = c[0] ? cur_word : $urandom;
      #1;
      check("strobes", {23'd0, active, mem_read, mem_write, iaddr_sel, pc_write,
                        reg_write, link, branch_taken, hilo_write}, {23'd0, e});
      if (c[1])
        check("decode", {4'd0, alu_op, alu_src_imm, imm, shamt}, cur_dec);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check(tag, {23'd0, active, mem_read, mem_write, iaddr_sel, pc_write,
                reg_write, link, branch_taken, hilo_write}, {23'd0, E_A});
    check({tag, "_dec"}, {4'd0, alu_op, alu_src_imm, imm, shamt}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_waitrequest = 1'b0;
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] word, input int fw, input int mw, input bit cond);
    logic [5:0] op;
    int         cls;
    bit         im;
    lookup(word, op, cls, im);
    cur_word = word;
    cur_dec  = {4'd0, op, im, word[15:0], word[10:6]};
    build(cls, fw, mw, cond);
    play(1000);
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (cls == C_ILL) do_reset();
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    int          idx;
    rst_n = 1'b0;
    instr_rdata = 32'd0;
    mem_waitrequest = 1'b0;
    alu_cond = 1'b0;
    fill_table();
    @(negedge clk);
    do_reset();

    // directed cases
    run_instr(32'h00851021, 0, 0, 1'b0);  // addu: F,D,E,WB
    run_instr(32'h8C830008, 0, 3, 1'b0);  // lw with 3 MEM wait states
    run_instr(32'h10220004, 0, 0, 1'b1);  // beq taken
    run_instr(32'h10220004, 0, 0, 1'b0);  // beq not taken
    run_instr(32'h00850018, 0, 0, 1'b0);  // mult
    run_instr(32'hFC000000, 0, 0, 1'b0);  // undecoded
    run_instr(32'h0C000010, 2, 0, 1'b0);  // jal, cond low still links
    run_instr(32'hAC830004, 1, 2, 1'b0);  // sw with waits

    // reset in the middle of a stalled load
    cur_word = 32'h8C830008;
    cur_dec  = {4'd0, 6'd23, 1'b1, 16'h0008, 5'd0};
    build(C_LD, 0, 5, 1'b0);
    play(5);
    exp_q.delete();
    ctl_q.delete();
    mem_waitrequest = 1'b1;
    #1;
    check("mem_hold", {31'd0, mem_read}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(32'h00851021, 1, 0, 1'b0);

    // randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      w = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 4))
          0: w[31:26] = 6'h3F;
          1: w[31:26] = 6'h08;
          2: w[31:26] = 6'h10;
          3: begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
          default: begin w[31:26] = 6'h01; w[20:16] = 5'h05; end
        endcase
      end else begin
        idx = $urandom_range(0, tab.size() - 1);
        w[31:26] = tab[idx].opc;
        if (tab[idx].opc == 6'h00) w[5:0] = tab[idx].sub;
        else if (tab[idx].opc == 6'h01) w[20:16] = tab[idx].sub[4:0];
      end
      run_instr(w, $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
